multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 246 ++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
//------------------------------------------------------------------------------
// Module   : multicycle_control
// Brief    : Multicycle MIPS-subset control FSM; optional MC_STATS_EN adds
//            retired-instruction and cycle counters.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_control #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       op,
   input  logic [5:0]       funct,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             memreq,
   output logic             memwrite,
   output logic             iord,
   output logic             irwrite,
   output logic             pcwrite,
   output logic [1:0]       pcsrc,
   output logic             regwrite,
   output logic             regdst,
   output logic             memtoreg,
   output logic [1:0]       alusrca,
   output logic [2:0]       alusrcb,
   output logic [2:0]       alucontrol,
   output logic             illegal
`ifdef MC_STATS_EN
   ,
   output logic [CNT_W-1:0] retired,
   output logic [CNT_W-1:0] cycles
`endif
);

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      RTEX    = 4'd6,
      RTWB    = 4'd7,
      IMMEX   = 4'd8,
      IMMWB   = 4'd9,
      BRANCH  = 4'd10,
      JUMP    = 4'd11,
      ILLEGAL = 4'd12
   } state_t;

   localparam logic [5:0] c_op_rtype = 6'b000000;
   localparam logic [5:0] c_op_lw    = 6'b100011;
   localparam logic [5:0] c_op_sw    = 6'b101011;
   localparam logic [5:0] c_op_addiu = 6'b001001;
   localparam logic [5:0] c_op_ori   = 6'b001101;
   localparam logic [5:0] c_op_lui   = 6'b001111;
   localparam logic [5:0] c_op_beq   = 6'b000100;
   localparam logic [5:0] c_op_j     = 6'b000010;

   localparam logic [2:0] c_alu_add  = 3'b010;
   localparam logic [2:0] c_alu_sub  = 3'b110;
   localparam logic [2:0] c_alu_and  = 3'b000;
   localparam logic [2:0] c_alu_or   = 3'b001;
   localparam logic [2:0] c_alu_sltu = 3'b111;

   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("CNT_W must be at least 1");
   end

   state_t     r_state;
   state_t     w_next;
   logic       w_funct_ok;
   logic [2:0] w_rt_alu;
   logic       w_memreq;
   logic       w_memwrite;
   logic       w_irwrite;
   logic       w_pcwrite;
   logic       w_regwrite;

   always_ff @(posedge clk) begin
      if (reset) r_state <= FETCH;
      else       r_state <= w_next;
   end

   always_comb begin
      w_funct_ok = 1'b1;
      w_rt_alu   = c_alu_add;
      case (funct)
         6'b100001: w_rt_alu = c_alu_add;
         6'b100011: w_rt_alu = c_alu_sub;
         6'b100100: w_rt_alu = c_alu_and;
         6'b100101: w_rt_alu = c_alu_or;
         6'b101011: w_rt_alu = c_alu_sltu;
         default: begin
            w_funct_ok = 1'b0;
            w_rt_alu   = 3'b000;
         end
      endcase
   end

   always_comb begin
      w_next     = r_state;
      w_memreq   = 1'b0;
      w_memwrite = 1'b0;
      w_irwrite  = 1'b0;
      w_pcwrite  = 1'b0;
      w_regwrite = 1'b0;
      iord       = 1'b0;
      pcsrc      = 2'b00;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      alusrca    = 2'b00;
      alusrcb    = 3'b000;
      alucontrol = 3'b000;
      case (r_state)
         FETCH: begin
            w_memreq   = 1'b1;
            alusrcb    = 3'b001;
            alucontrol = c_alu_add;
            if (mem_ready) begin
               w_irwrite = 1'b1;
               w_pcwrite = 1'b1;
               w_next    = DECODE;
            end
         end
         DECODE: begin
            alusrcb    = 3'b101;
            alucontrol = c_alu_add;
            case (op)
               c_op_rtype:                    w_next = w_funct_ok ? RTEX : ILLEGAL;
               c_op_lw, c_op_sw:              w_next = MEMADR;
               c_op_addiu, c_op_ori, c_op_lui: w_next = IMMEX;
               c_op_beq:                      w_next = BRANCH;
               c_op_j:                        w_next = JUMP;
               default:                       w_next = ILLEGAL;
            endcase
         end
         MEMADR: begin
            alusrca    = 2'b01;
            alusrcb    = 3'b010;
            alucontrol = c_alu_add;
            w_next     = (op == c_op_lw) ? MEMRD : MEMWR;
         end
         MEMRD: begin
            w_memreq = 1'b1;
            iord     = 1'b1;
            if (mem_ready) w_next = MEMWB;
         end
         MEMWB: begin
            w_regwrite = 1'b1;
            memtoreg   = 1'b1;
            w_next     = FETCH;
         end
         MEMWR: begin
            w_memreq   = 1'b1;
            w_memwrite = 1'b1;
            iord       = 1'b1;
            if (mem_ready) w_next = FETCH;
         end
         RTEX: begin
            alusrca    = 2'b01;
            alucontrol = w_rt_alu;
            w_next     = RTWB;
         end
         RTWB: begin
            w_regwrite = 1'b1;
            regdst     = 1'b1;
            w_next     = FETCH;
         end
         IMMEX: begin
            case (op)
               c_op_ori: begin
                  alusrca    = 2'b01;
                  alusrcb    = 3'b011;
                  alucontrol = c_alu_or;
               end
               c_op_lui: begin
                  alusrca    = 2'b10;
                  alusrcb    = 3'b100;
                  alucontrol = c_alu_add;
               end
               default: begin
                  alusrca    = 2'b01;
                  alusrcb    = 3'b010;
                  alucontrol = c_alu_add;
               end
            endcase
            w_next = IMMWB;
         end
         IMMWB: begin
            w_regwrite = 1'b1;
            w_next     = FETCH;
         end
         BRANCH: begin
            alusrca    = 2'b01;
            alucontrol = c_alu_sub;
            pcsrc      = 2'b01;
            w_pcwrite  = zero;
            w_next     = FETCH;
         end
         JUMP: begin
            pcsrc     = 2'b10;
            w_pcwrite = 1'b1;
            w_next    = FETCH;
         end
         ILLEGAL: w_next = ILLEGAL;
         default: w_next = FETCH;
      endcase
   end

   // Strobes are masked by reset so an in-flight access is dropped immediately.
   assign memreq   = w_memreq   & ~reset;
   assign memwrite = w_memwrite & ~reset;
   assign irwrite  = w_irwrite  & ~reset;
   assign pcwrite  = w_pcwrite  & ~reset;
   assign regwrite = w_regwrite & ~reset;
   assign illegal  = (r_state == ILLEGAL);

`ifdef MC_STATS_EN
   logic [CNT_W-1:0] r_retired;
   logic [CNT_W-1:0] r_cycles;
   logic             w_retire;

   assign w_retire = (w_next == FETCH) &&
                     (r_state inside {MEMWB, MEMWR, RTWB, IMMWB, BRANCH, JUMP});

   always_ff @(posedge clk) begin
      if (reset) begin
         r_retired <= '0;
         r_cycles  <= '0;
      end else begin
         r_cycles <= r_cycles + 1'b1;
         if (w_retire) r_retired <= r_retired + 1'b1;
      end
   end

   assign retired = r_retired;
   assign cycles  = r_cycles;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
//------------------------------------------------------------------------------
// Module   : tb_multicycle_control
// Brief    : Directed bench for multicycle_control (stats checks with MC_STATS_EN).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       memreq, memwrite, iord, irwrite, pcwrite, regwrite, regdst, memtoreg, illegal;
   logic [1:0] pcsrc, alusrca;
   logic [2:0] alusrcb, alucontrol;
`ifdef MC_STATS_EN
   logic [3:0] retired, cycles;
`endif

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   multicycle_control #(.CNT_W(4)) dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .memreq(memreq), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
      .pcwrite(pcwrite), .pcsrc(pcsrc), .regwrite(regwrite), .regdst(regdst),
      .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb),
      .alucontrol(alucontrol), .illegal(illegal)
`ifdef MC_STATS_EN
      , .retired(retired), .cycles(cycles)
`endif
   );

   // {memreq,memwrite,iord,irwrite,pcwrite,pcsrc,regwrite,regdst,memtoreg,alusrca,alusrcb,alucontrol,illegal}
   localparam logic [18:0] FETCH_RDY  = 19'b1_0_0_1_1_00_0_0_0_00_001_010_0;
   localparam logic [18:0] FETCH_WAIT = 19'b1_0_0_0_0_00_0_0_0_00_001_010_0;
   localparam logic [18:0] FETCH_RST  = 19'b0_0_0_0_0_00_0_0_0_00_001_010_0;
   localparam logic [18:0] DECODE_V   = 19'b0_0_0_0_0_00_0_0_0_00_101_010_0;
   localparam logic [18:0] RTWB_V     = 19'b0_0_0_0_0_00_1_1_0_00_000_000_0;
   localparam logic [18:0] IMMWB_V    = 19'b0_0_0_0_0_00_1_0_0_00_000_000_0;
   localparam logic [18:0] MEMWB_V    = 19'b0_0_0_0_0_00_1_0_1_00_000_000_0;
   localparam logic [18:0] MEMWR_V    = 19'b1_1_1_0_0_00_0_0_0_00_000_000_0;
   localparam logic [18:0] MEMADR_V   = 19'b0_0_0_0_0_00_0_0_0_01_010_010_0;
   localparam logic [18:0] ILLEGAL_V  = 19'b0_0_0_0_0_00_0_0_0_00_000_000_1;

   typedef struct {
      logic [5:0]  op;
      logic [5:0]  funct;
      logic        zero;
      int          len;
      logic [18:0] ex;
      logic [18:0] wb;
   } vec_t;

   vec_t tbl [13];

   function automatic logic [18:0] pack();
      return {memreq, memwrite, iord, irwrite, pcwrite, pcsrc, regwrite, regdst,
              memtoreg, alusrca, alusrcb, alucontrol, illegal};
   endfunction

   function automatic bit is_fetch(input logic [18:0] v);
      return v[18] && !v[16] && (v[6:4] == 3'b001);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(negedge clk);
      #1;
   endtask

   // Entered and left at a FETCH negedge; runs one instruction with no waits.
   task automatic run_vec(input vec_t v, input int idx);
      logic [18:0] cur;
      logic [18:0] last;
      int          n;
      bit          done;
      op = v.op; funct = v.funct; zero = v.zero; mem_ready = 1'b1;
      #1;
      chk($sformatf("v%0d fetch", idx), 32'(pack()), 32'(FETCH_RDY));
      n = 1; done = 0; last = '0;
      for (int c = 2; c <= 12 && !done; c++) begin
         next_cycle();
         cur = pack();
         if (is_fetch(cur)) done = 1;
         else begin
            n = c;
            last = cur;
            if (c == 2) chk($sformatf("v%0d decode", idx), 32'(cur), 32'(DECODE_V));
            if (c == 3) chk($sformatf("v%0d exec", idx), 32'(cur), 32'(v.ex));
         end
      end
      chk($sformatf("v%0d latency", idx), 32'(n), 32'(v.len));
      chk($sformatf("v%0d final", idx), 32'(last), 32'(v.wb));
   endtask

   initial begin
      logic [18:0] cur;
      int          n;
      int          rw;
      bit          done;

      tbl[0]  = '{6'b000000, 6'b100001, 1'b0, 4, 19'b0_0_0_0_0_00_0_0_0_01_000_010_0, RTWB_V};
      tbl[1]  = '{6'b000000, 6'b100011, 1'b0, 4, 19'b0_0_0_0_0_00_0_0_0_01_000_110_0, RTWB_V};
      tbl[2]  = '{6'b000000, 6'b100100, 1'b0, 4, 19'b0_0_0_0_0_00_0_0_0_01_000_000_0, RTWB_V};
      tbl[3]  = '{6'b000000, 6'b100101, 1'b0, 4, 19'b0_0_0_0_0_00_0_0_0_01_000_001_0, RTWB_V};
      tbl[4]  = '{6'b000000, 6'b101011, 1'b0, 4, 19'b0_0_0_0_0_00_0_0_0_01_000_111_0, RTWB_V};
      tbl[5]  = '{6'b001001, 6'b000000, 1'b0, 4, 19'b0_0_0_0_0_00_0_0_0_01_010_010_0, IMMWB_V};
      tbl[6]  = '{6'b001101, 6'b000000, 1'b0, 4, 19'b0_0_0_0_0_00_0_0_0_01_011_001_0, IMMWB_V};
      tbl[7]  = '{6'b001111, 6'b000000, 1'b0, 4, 19'b0_0_0_0_0_00_0_0_0_10_100_010_0, IMMWB_V};
      tbl[8]  = '{6'b100011, 6'b000000, 1'b0, 5, MEMADR_V, MEMWB_V};
      tbl[9]  = '{6'b101011, 6'b000000, 1'b0, 4, MEMADR_V, MEMWR_V};
      tbl[10] = '{6'b000100, 6'b000000, 1'b1, 3, 19'b0_0_0_0_1_01_0_0_0_01_000_110_0,
                                                 19'b0_0_0_0_1_01_0_0_0_01_000_110_0};
      tbl[11] = '{6'b000100, 6'b000000, 1'b0, 3, 19'b0_0_0_0_0_01_0_0_0_01_000_110_0,
                                                 19'b0_0_0_0_0_01_0_0_0_01_000_110_0};
      tbl[12] = '{6'b000010, 6'b000000, 1'b0, 3, 19'b0_0_0_0_1_10_0_0_0_00_000_000_0,
                                                 19'b0_0_0_0_1_10_0_0_0_00_000_000_0};

      reset = 1'b1; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
      repeat (3) @(posedge clk);
      next_cycle();
      chk("reset outputs", 32'(pack()), 32'(FETCH_RST));
      reset = 1'b0;
      #1;
      chk("fetch idle", 32'(pack()), 32'(FETCH_WAIT));

      for (int i = 0; i < 13; i++) run_vec(tbl[i], i);

      // lw stalled three cycles in MEMRD
      op = 6'b100011; mem_ready = 1'b1;
      #1;
      n = 1; rw = 0; done = 0;
      for (int c = 2; c <= 14 && !done; c++) begin
         @(negedge clk);
         mem_ready = !(c >= 4 && c <= 6);
         #1;
         cur = pack();
         if (is_fetch(cur)) done = 1;
         else begin
            n = c;
            rw += int'(cur[11]);
            if (c >= 4 && c <= 6) chk($sformatf("lw stall c%0d", c), 32'(cur[18:16]), 32'b101);
            if (c == 8) chk("lw memwb", 32'(cur), 32'(MEMWB_V));
         end
      end
      chk("lw stall latency", 32'(n), 32'd8);
      chk("lw regwrite count", 32'(rw), 32'd1);

      // sw waiting in MEMWR, then reset mid-access
      op = 6'b101011; mem_ready = 1'b1;
      #1;
      next_cycle();
      next_cycle();
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      chk("sw memwr", 32'(pack()), 32'(MEMWR_V));
      next_cycle();
      chk("sw memwr hold", 32'(pack()), 32'(MEMWR_V));
      reset = 1'b1;
      #1;
      chk("sw reset strobes", 32'({memreq, memwrite, irwrite, pcwrite, regwrite}), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("sw reset to fetch", 32'(pack()), 32'(FETCH_WAIT));
`ifdef MC_STATS_EN
      chk("reset retired", 32'(retired), 32'd0);
      chk("reset cycles", 32'(cycles), 32'd0);
`endif

      // undefined opcode
      op = 6'b111111; mem_ready = 1'b1;
      #1;
      next_cycle();
      chk("ill decode", 32'(pack()), 32'(DECODE_V));
      for (int c = 0; c < 10; c++) begin
         next_cycle();
         chk($sformatf("ill hold %0d", c), 32'(pack()), 32'(ILLEGAL_V));
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0; mem_ready = 1'b0;
      #1;
      chk("ill reset", 32'(pack()), 32'(FETCH_WAIT));

      // R-type with undefined funct
      op = 6'b000000; funct = 6'b000000; mem_ready = 1'b1;
      #1;
      next_cycle();
      next_cycle();
      chk("bad funct", 32'(pack()), 32'(ILLEGAL_V));
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0; mem_ready = 1'b0;
      #1;
      chk("bad funct reset", 32'(pack()), 32'(FETCH_WAIT));

`ifdef MC_STATS_EN
      // 20 jumps back to back = 60 cycles with CNT_W = 4
      op = 6'b000010; mem_ready = 1'b1;
      repeat (60) @(posedge clk);
      next_cycle();
      chk("stats retired", 32'(retired), 32'd4);
      chk("stats cycles", 32'(cycles), 32'd12);
      chk("stats in fetch", 32'(is_fetch(pack())), 32'd1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

`default_nettype wire
